axi_read_arbiter: RTL and testbench

Two-requester AXI4 read-channel arbiter between the instruction cache (I-side) and the data cache (D-side) and the single AXI read port to the memory interconnect. It carries one burst at a time, round-robin fair. It forwards the granted cache's AR request into registered master outputs and steers R beats back to that cache until `rlast`. Both caches need no change to their AR/R handshakes.

---
 rtl/axi_read_arbiter.sv | 139 +++++++++++++
 tb/tb_axi_read_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Brief    : Round-robin AXI4 read arbiter between I-cache and D-cache, one
//            burst outstanding at a time, registered AR and pass-through R.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0] c_BURST_INCR = 2'b01;

    state_t      r_state;
    logic        r_grant;
    logic        r_last;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic        r_arvalid;

    logic w_req;
    logic w_pick;
    logic w_in_addr;
    logic w_in_data;

    assign w_req     = i_arvalid | d_arvalid;
    // On a tie the side that was not served last wins; otherwise the lone requester.
    assign w_pick    = (i_arvalid & d_arvalid) ? ~r_last : d_arvalid;
    assign w_in_addr = (r_state == S_ADDR);
    assign w_in_data = (r_state == S_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_arid    <= ID_I;
            r_araddr  <= 32'd0;
            r_arlen   <= 8'd0;
            r_arsize  <= 3'd0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_grant   <= w_pick;
                        r_last    <= w_pick;
                        r_arid    <= w_pick ? ID_D : ID_I;
                        r_araddr  <= w_pick ? d_araddr : i_araddr;
                        r_arlen   <= w_pick ? d_arlen  : i_arlen;
                        r_arsize  <= w_pick ? d_arsize : i_arsize;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (r_arvalid & m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_rvalid & m_rready & m_rlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign m_arid    = r_arid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = r_arsize;
    assign m_arburst = c_BURST_INCR;
    assign m_arvalid = r_arvalid;

    assign i_arready = w_in_addr & ~r_grant & m_arready;
    assign d_arready = w_in_addr &  r_grant & m_arready;

    // R path is purely combinational so beats see no added latency.
    assign m_rready  = w_in_data & (r_grant ? d_rready : i_rready);
    assign i_rvalid  = w_in_data & ~r_grant & m_rvalid;
    assign d_rvalid  = w_in_data &  r_grant & m_rvalid;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign i_rlast   = m_rlast;
    assign d_rlast   = m_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter
// Brief    : Scoreboard bench for axi_read_arbiter with a one-burst memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic [2:0]  i_arsize = '0;
    logic        i_arvalid = 1'b0;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready = 1'b1;

    logic [31:0] d_araddr = '0;
    logic [7:0]  d_arlen = '0;
    logic [2:0]  d_arsize = '0;
    logic        d_arvalid = 1'b0;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready = 1'b1;

    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready = 1'b1;
    logic [31:0] m_rdata = '0;
    logic        m_rlast = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    axi_read_arbiter #(.ID_I(4'd0), .ID_D(4'd1)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    ar_t         ar_q[$];
    logic [32:0] i_q[$];
    logic [32:0] d_q[$];

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int outstanding = 0;
    int i_arr_cnt = 0;
    int d_rv_cnt = 0;
    int stall_cycles = 0;
    int d_hs_cnt = 0;
    int rlast_cyc = 0;
    int last_gap = 0;
    int stall_cnt = 0;
    logic tog_i = 1'b0;

    function automatic logic [31:0] beat_data(input logic [31:0] b, input logic [7:0] k);
        return (b + {22'd0, k, 2'b00}) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic expect_burst(input bit side, input logic [31:0] a,
                                input logic [7:0] l, input logic [2:0] s);
        ar_t e;
        e.id = side ? 4'd1 : 4'd0;
        e.addr = a;
        e.len = l;
        e.size = s;
        ar_q.push_back(e);
        for (int k = 0; k <= int'(l); k++) begin
            if (side) d_q.push_back({k == int'(l), beat_data(a, 8'(k))});
            else      i_q.push_back({k == int'(l), beat_data(a, 8'(k))});
        end
    endtask

    task automatic drive(input bit side, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s);
        int n;
        logic rdy;
        n = 0;
        if (side) begin
            d_araddr = a; d_arlen = l; d_arsize = s; d_arvalid = 1'b1;
        end else begin
            i_araddr = a; i_arlen = l; i_arsize = s; i_arvalid = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
            rdy = side ? d_arready : i_arready;
        end while (!rdy && n < 300);
        chk(side ? "d_ar_handshake" : "i_ar_handshake", 64'(rdy), 64'd1);
        @(posedge clk); #1;
        if (side) d_arvalid = 1'b0;
        else      i_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((ar_q.size() != 0 || i_q.size() != 0 || d_q.size() != 0 || outstanding != 0)
               && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk(nm, 64'(n < 1000), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {9'd0, m_arvalid, m_araddr, m_arlen, m_arsize, m_arid, m_arburst,
                 i_arready, d_arready, i_rvalid, d_rvalid, m_rready},
                {9'd0, 1'b0, 32'd0, 8'd0, 3'd0, 4'd0, 2'b01, 5'b00000});
    endtask

    // Memory model: accepts one AR, then streams beats, honouring m_rready.
    logic        sl_active = 1'b0;
    logic [31:0] sl_base = '0;
    logic [7:0]  sl_len = '0;
    logic [7:0]  sl_beat = '0;

    always begin : p_slave
        logic s_ar, s_r, s_rst, s_arv;
        logic [31:0] s_a;
        logic [7:0]  s_l;
        @(negedge clk);
        s_ar  = m_arvalid & m_arready;
        s_r   = m_rvalid & m_rready;
        s_rst = rst;
        s_arv = m_arvalid;
        s_a   = m_araddr;
        s_l   = m_arlen;
        @(posedge clk); #1;
        if (s_rst) begin
            sl_active = 1'b0;
        end else begin
            if (s_r) begin
                if (sl_beat == sl_len) sl_active = 1'b0;
                else sl_beat = sl_beat + 8'd1;
            end
            if (s_ar) begin
                sl_active = 1'b1;
                sl_base = s_a;
                sl_len = s_l;
                sl_beat = 8'd0;
            end
        end
        if (s_arv && stall_cnt > 0) stall_cnt--;
        m_arready = (stall_cnt == 0);
        m_rvalid  = sl_active;
        m_rdata   = sl_active ? beat_data(sl_base, sl_beat) : 32'hDEAD_BEEF;
        m_rlast   = sl_active && (sl_beat == sl_len);
    end

    always begin : p_rready
        @(posedge clk); #1;
        i_rready = tog_i ? ~i_rready : 1'b1;
        d_rready = 1'b1;
    end

    logic prev_arv = 1'b0;
    logic prev_arr = 1'b0;
    logic [31:0] prev_addr = '0;

    always begin : p_mon
        ar_t e;
        logic [32:0] x;
        @(negedge clk);
        cyc++;
        if (rst) begin
            outstanding = 0;
            prev_arv = 1'b0;
        end else begin
            if (m_arvalid && m_arready) begin
                chk("no_overlap", 64'(outstanding), 64'd0);
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", 64'(m_araddr), 64'hFFFF_FFFF_FFFF);
                end else begin
                    e = ar_q.pop_front();
                    chk("ar_fields", {15'd0, m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                                     {15'd0, e.id, e.addr, e.len, e.size, 2'b01});
                end
                outstanding++;
            end
            if (prev_arv && !prev_arr)
                chk("ar_stable", {31'd0, m_arvalid, m_araddr}, {31'd0, 1'b1, prev_addr});
            if (m_arvalid && !prev_arv) last_gap = cyc - rlast_cyc;
            if (m_arvalid && !m_arready) stall_cycles++;
            if (i_arready) i_arr_cnt++;
            if (d_rvalid) d_rv_cnt++;
            if (m_rvalid) begin
                chk("r_steer", {61'd0, i_rvalid, d_rvalid, m_arvalid},
                    {61'd0, i_rvalid, ~i_rvalid, 1'b0});
                chk("m_rready_mirror", 64'(m_rready), 64'(i_rvalid ? i_rready : d_rready));
            end
            if (i_rvalid && i_rready) begin
                if (i_q.size() == 0) chk("i_beat_unexpected", 64'(i_rdata), 64'hFFFF_FFFF_FFFF);
                else begin
                    x = i_q.pop_front();
                    chk("i_beat", 64'({i_rlast, i_rdata}), 64'(x));
                end
            end
            if (d_rvalid && d_rready) begin
                d_hs_cnt++;
                if (d_q.size() == 0) chk("d_beat_unexpected", 64'(d_rdata), 64'hFFFF_FFFF_FFFF);
                else begin
                    x = d_q.pop_front();
                    chk("d_beat", 64'({d_rlast, d_rdata}), 64'(x));
                end
            end
            if (m_rvalid && m_rready && m_rlast) begin
                rlast_cyc = cyc;
                outstanding--;
            end
            prev_arv = m_arvalid;
        end
        prev_arr  = m_arready;
        prev_addr = m_araddr;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int n;
        int base;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_state");

        // Single I-side burst with latency check
        @(posedge clk); #1;
        i_arr_cnt = 0;
        d_rv_cnt = 0;
        expect_burst(1'b0, 32'h1FC0_0020, 8'd7, 3'd2);
        fork
            drive(1'b0, 32'h1FC0_0020, 8'd7, 3'd2);
            begin
                @(negedge clk);
                chk("t1_arvalid_before", 64'(m_arvalid), 64'd0);
                @(negedge clk);
                chk("t1_ar_next_cycle", {19'd0, m_arvalid, m_araddr, m_arlen, m_arid},
                                        {19'd0, 1'b1, 32'h1FC0_0020, 8'd7, 4'd0});
            end
        join
        wait_drain("t1_drain");
        chk("t1_arready_pulses", 64'(i_arr_cnt), 64'd1);
        chk("t1_d_rvalid_quiet", 64'(d_rv_cnt), 64'd0);

        // Simultaneous requests from reset: I first, D two cycles after I's rlast
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        expect_burst(1'b0, 32'h0000_0100, 8'd3, 3'd2);
        expect_burst(1'b1, 32'h0000_0200, 8'd2, 3'd2);
        fork
            drive(1'b0, 32'h0000_0100, 8'd3, 3'd2);
            drive(1'b1, 32'h0000_0200, 8'd2, 3'd2);
        join
        wait_drain("t2_drain");
        chk("t2_turnaround_gap", 64'(last_gap), 64'd2);

        // Continuous requests: I, D, I, D
        expect_burst(1'b0, 32'h0000_1000, 8'd1, 3'd2);
        expect_burst(1'b1, 32'h0000_2000, 8'd2, 3'd2);
        expect_burst(1'b0, 32'h0000_1100, 8'd3, 3'd2);
        expect_burst(1'b1, 32'h0000_2100, 8'd0, 3'd2);
        fork
            begin
                drive(1'b0, 32'h0000_1000, 8'd1, 3'd2);
                drive(1'b0, 32'h0000_1100, 8'd3, 3'd2);
            end
            begin
                drive(1'b1, 32'h0000_2000, 8'd2, 3'd2);
                drive(1'b1, 32'h0000_2100, 8'd0, 3'd2);
            end
        join
        wait_drain("t3_drain");

        // Backpressure on AR and toggling i_rready
        stall_cnt = 5;
        @(posedge clk); #1;
        stall_cycles = 0;
        tog_i = 1'b1;
        expect_burst(1'b0, 32'h0000_3000, 8'd5, 3'd2);
        drive(1'b0, 32'h0000_3000, 8'd5, 3'd2);
        wait_drain("t4_drain");
        tog_i = 1'b0;
        chk("t4_stall_cycles", 64'(stall_cycles), 64'd5);

        // Reset on beat 3 of an 8-beat D burst
        base = d_hs_cnt;
        expect_burst(1'b1, 32'h0000_4000, 8'd7, 3'd2);
        drive(1'b1, 32'h0000_4000, 8'd7, 3'd2);
        n = 0;
        while (d_hs_cnt < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reach_beat3", 64'(n < 200), 64'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset_midburst");
        d_q.delete();
        ar_q.delete();
        @(posedge clk); #1;
        expect_burst(1'b0, 32'h0000_5000, 8'd2, 3'd2);
        drive(1'b0, 32'h0000_5000, 8'd2, 3'd2);
        wait_drain("t5_drain");

        // Uncached single beats back to back
        expect_burst(1'b1, 32'h0000_6000, 8'd0, 3'd2);
        expect_burst(1'b1, 32'h0000_6040, 8'd0, 3'd2);
        drive(1'b1, 32'h0000_6000, 8'd0, 3'd2);
        drive(1'b1, 32'h0000_6040, 8'd0, 3'd2);
        wait_drain("t6_drain");
        chk("t6_single_beat_gap", 64'(last_gap), 64'd2);

        chk("queues_empty", 64'(ar_q.size() + i_q.size() + d_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
